// File: rtl/nios2_ocimem_monitor_port.sv
// Debug-memory monitor port: turns JTAG ocimem strobes into single-word Avalon reads/writes.
// Latency: request the cycle after a strobe; ready the cycle after the slave completes.
// Backpressure: mem_waitrequest holds the request; TIMEOUT_CYCLES aborts a stuck transfer.
module nios2_ocimem_monitor_port #(
    parameter int ADDR_W         = 8,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [37:0]       jdo,
    input  logic              take_action_ocimem_a,
    input  logic              take_no_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    output logic [31:0]       MonDReg,
    output logic [ADDR_W-1:0] MonAReg,
    output logic              monitor_ready,
    output logic              monitor_error,
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read,
    output logic              mem_write,
    output logic [31:0]       mem_writedata,
    input  logic              mem_waitrequest,
    input  logic [31:0]       mem_readdata,
    input  logic              mem_readdatavalid
);
    typedef enum logic [1:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ} state_t;

    localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);

    state_t            state, state_nxt;
    logic [15:0]       tmo_cnt;
    logic [31:0]       dreg_nxt, wdata_nxt;
    logic [ADDR_W-1:0] areg_nxt;
    logic              ready_nxt, error_nxt;
    logic              any_strobe, tmo_hit;
    logic              jdo_unused;

    assign any_strobe  = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;
    assign tmo_hit     = (tmo_cnt == TMO_LAST);
    assign mem_address = MonAReg;
    assign mem_read    = (state == RD_REQ);
    assign mem_write   = (state == WR_REQ);
    assign jdo_unused  = ^{jdo[37:36], jdo[1:0]};

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state         <= IDLE;
            tmo_cnt       <= '0;
            MonDReg       <= '0;
            MonAReg       <= '0;
            mem_writedata <= '0;
            monitor_ready <= 1'b0;
            monitor_error <= 1'b0;
        end else begin
            state         <= state_nxt;
            tmo_cnt       <= (state == IDLE) ? 16'd0 : tmo_cnt + 16'd1;
            MonDReg       <= dreg_nxt;
            MonAReg       <= areg_nxt;
            mem_writedata <= wdata_nxt;
            monitor_ready <= ready_nxt;
            monitor_error <= error_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        dreg_nxt  = MonDReg;
        areg_nxt  = MonAReg;
        wdata_nxt = mem_writedata;
        ready_nxt = monitor_ready;
        error_nxt = monitor_error;
        case (state)
            IDLE: begin
                if (take_action_ocimem_b) begin
                    wdata_nxt = jdo[34:3];
                    ready_nxt = 1'b0;
                    state_nxt = WR_REQ;
                end else if (take_action_ocimem_a) begin
                    areg_nxt = jdo[ADDR_W+1:2];
                    if (jdo[35]) error_nxt = 1'b0;
                    if (jdo[34]) begin
                        ready_nxt = 1'b0;
                        state_nxt = RD_REQ;
                    end else begin
                        ready_nxt = 1'b1;
                    end
                end else if (take_no_action_ocimem_a) begin
                    areg_nxt  = MonAReg + 1'b1;
                    ready_nxt = 1'b0;
                    state_nxt = RD_REQ;
                end
            end
            RD_REQ: begin
                // Slave may accept and return data in the same cycle.
                if (!mem_waitrequest && mem_readdatavalid) begin
                    dreg_nxt  = mem_readdata;
                    ready_nxt = 1'b1;
                    state_nxt = IDLE;
                end else if (tmo_hit) begin
                    ready_nxt = 1'b1;
                    error_nxt = 1'b1;
                    state_nxt = IDLE;
                end else if (!mem_waitrequest) begin
                    state_nxt = RD_WAIT;
                end
            end
            RD_WAIT: begin
                if (mem_readdatavalid) begin
                    dreg_nxt  = mem_readdata;
                    ready_nxt = 1'b1;
                    state_nxt = IDLE;
                end else if (tmo_hit) begin
                    ready_nxt = 1'b1;
                    error_nxt = 1'b1;
                    state_nxt = IDLE;
                end
            end
            WR_REQ: begin
                if (!mem_waitrequest) begin
                    areg_nxt  = MonAReg + 1'b1;
                    ready_nxt = 1'b1;
                    state_nxt = IDLE;
                end else if (tmo_hit) begin
                    ready_nxt = 1'b1;
                    error_nxt = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        // A command arriving while busy is dropped but leaves a sticky error.
        if (state != IDLE && any_strobe) error_nxt = 1'b1;
    end
endmodule

// File: tb/tb_nios2_ocimem_monitor_port.sv
// Randomized scoreboard bench for nios2_ocimem_monitor_port with a word-level memory model.
module tb_nios2_ocimem_monitor_port;
    localparam int AW  = 8;
    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          reset_n;
    logic [37:0]   jdo;
    logic          take_action_ocimem_a, take_no_action_ocimem_a, take_action_ocimem_b;
    logic [31:0]   MonDReg;
    logic [AW-1:0] MonAReg;
    logic          monitor_ready, monitor_error;
    logic [AW-1:0] mem_address;
    logic          mem_read, mem_write;
    logic [31:0]   mem_writedata;
    logic          mem_waitrequest;
    logic [31:0]   mem_readdata;
    logic          mem_readdatavalid;

    always #5 clk = ~clk;

    nios2_ocimem_monitor_port #(.ADDR_W(AW), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .reset_n(reset_n), .jdo(jdo),
        .take_action_ocimem_a(take_action_ocimem_a),
        .take_no_action_ocimem_a(take_no_action_ocimem_a),
        .take_action_ocimem_b(take_action_ocimem_b),
        .MonDReg(MonDReg), .MonAReg(MonAReg),
        .monitor_ready(monitor_ready), .monitor_error(monitor_error),
        .mem_address(mem_address), .mem_read(mem_read), .mem_write(mem_write),
        .mem_writedata(mem_writedata), .mem_waitrequest(mem_waitrequest),
        .mem_readdata(mem_readdata), .mem_readdatavalid(mem_readdatavalid)
    );

    typedef struct packed { logic wr; logic [7:0] a; logic [31:0] d; } bus_t;
    typedef struct packed { logic [31:0] d; logic [7:0] a; logic e; } done_t;

    bus_t  bus_q[$];
    done_t done_q[$];

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] ref_mem[256];
    logic [31:0] slave_mem[256];
    logic [7:0]  ref_addr;
    logic [31:0] ref_dreg;
    logic        ref_err, ref_ready;

    int cfg_stall = -1;
    int cfg_lat   = -1;
    bit hold_wait = 1'b0;

    task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model ----------------
    task automatic push_done();
        done_q.push_back({ref_dreg, ref_addr, ref_err});
    endtask

    task automatic model_read(input logic [7:0] a);
        bus_q.push_back({1'b0, a, 32'h0});
        ref_dreg  = ref_mem[a];
        ref_ready = 1'b1;
        push_done();
    endtask

    task automatic model_load(input logic [7:0] a, input logic rd, input logic clr);
        ref_addr = a;
        if (clr) ref_err = 1'b0;
        if (rd) model_read(a);
        else begin
            if (!ref_ready) push_done();
            ref_ready = 1'b1;
        end
    endtask

    task automatic model_inc();
        ref_addr = ref_addr + 8'd1;
        model_read(ref_addr);
    endtask

    task automatic model_write(input logic [31:0] d);
        bus_q.push_back({1'b1, ref_addr, d});
        ref_mem[ref_addr] = d;
        ref_addr  = ref_addr + 8'd1;
        ref_ready = 1'b1;
        push_done();
    endtask

    // ---------------- stimulus helpers ----------------
    function automatic logic [37:0] rnd_jdo();
        return 38'({$urandom(), $urandom()});
    endfunction

    function automatic logic [37:0] mk_load(input logic [7:0] a, input logic rd, input logic clr);
        logic [37:0] j;
        j = rnd_jdo();
        j[9:2] = a;
        j[34]  = rd;
        j[35]  = clr;
        return j;
    endfunction

    function automatic logic [37:0] mk_write(input logic [31:0] d);
        logic [37:0] j;
        j = rnd_jdo();
        j[34:3] = d;
        return j;
    endfunction

    task automatic strobe(input logic a, input logic na, input logic b, input logic [37:0] j);
        @(negedge clk);
        jdo = j;
        take_action_ocimem_a    = a;
        take_no_action_ocimem_a = na;
        take_action_ocimem_b    = b;
        @(negedge clk);
        take_action_ocimem_a    = 1'b0;
        take_no_action_ocimem_a = 1'b0;
        take_action_ocimem_b    = 1'b0;
        jdo = rnd_jdo();
    endtask

    task automatic wait_done(output int nreq);
        int n = 0;
        nreq = 0;
        while (monitor_ready !== 1'b1 && n < 100) begin
            if (mem_read || mem_write) nreq++;
            @(negedge clk);
            n++;
        end
        if (monitor_ready !== 1'b1) begin
            n_checks++;
            n_fail++;
            $display("FAIL wait_done: monitor_ready=%0b after %0d cycles", monitor_ready, n);
        end
    endtask

    // ---------------- Avalon slave ----------------
    initial begin
        int stall, lat, lat_cnt;
        bit busy;
        logic [31:0] pend;
        stall = 0; lat = 0; lat_cnt = 0; busy = 1'b0; pend = '0;
        mem_waitrequest = 1'b0; mem_readdatavalid = 1'b0; mem_readdata = '0;
        forever begin
            @(posedge clk);
            #1;
            mem_readdatavalid = 1'b0;
            mem_readdata      = $urandom();
            if (lat_cnt > 0) begin
                lat_cnt--;
                if (lat_cnt == 0) begin
                    mem_readdatavalid = 1'b1;
                    mem_readdata      = pend;
                end
            end
            if (!(mem_read || mem_write)) begin
                busy = 1'b0;
                mem_waitrequest = 1'b0;
            end else begin
                if (!busy) begin
                    busy  = 1'b1;
                    stall = (cfg_stall < 0) ? int'($urandom_range(0, 2)) : cfg_stall;
                end
                if (hold_wait) mem_waitrequest = 1'b1;
                else if (stall > 0) begin
                    mem_waitrequest = 1'b1;
                    stall--;
                end else begin
                    mem_waitrequest = 1'b0;
                    busy = 1'b0;
                    if (mem_write) slave_mem[mem_address] = mem_writedata;
                    else begin
                        pend = slave_mem[mem_address];
                        lat  = (cfg_lat < 0) ? int'($urandom_range(0, 2)) : cfg_lat;
                        if (lat == 0) begin
                            mem_readdatavalid = 1'b1;
                            mem_readdata      = pend;
                        end else lat_cnt = lat;
                    end
                end
            end
        end
    end

    // ---------------- monitors ----------------
    initial begin
        bus_t e;
        forever begin
            @(negedge clk);
            if ((mem_read || mem_write) && !mem_waitrequest) begin
                if (bus_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL bus_unexpected: wr=%0b addr=%0h", mem_write, mem_address);
                end else begin
                    e = bus_q.pop_front();
                    check("bus_xfer", {mem_write, mem_address, mem_write ? mem_writedata : 32'h0},
                          {e.wr, e.a, e.wr ? e.d : 32'h0});
                end
            end
        end
    end

    initial begin
        done_t e;
        logic prev_ready;
        prev_ready = 1'bx;
        forever begin
            @(negedge clk);
            if (prev_ready === 1'b0 && monitor_ready === 1'b1) begin
                if (done_q.size() == 0) begin
                    n_checks++;
                    n_fail++;
                    $display("FAIL done_unexpected: dreg=%0h areg=%0h err=%0b", MonDReg, MonAReg, monitor_error);
                end else begin
                    e = done_q.pop_front();
                    check("done", {MonDReg, MonAReg, monitor_error}, {e.d, e.a, e.e});
                end
            end
            prev_ready = monitor_ready;
        end
    end

    // ---------------- main sequence ----------------
    initial begin
        int nreq;
        logic [37:0] j;
        logic [7:0] a;
        logic rd, clr;
        for (int i = 0; i < 256; i++) begin
            ref_mem[i]   = $urandom();
            slave_mem[i] = ref_mem[i];
        end
        ref_mem[8'h3C] = 32'hCAFEF00D;
        slave_mem[8'h3C] = 32'hCAFEF00D;
        ref_addr = '0; ref_dreg = '0; ref_err = 1'b0; ref_ready = 1'b0;
        reset_n = 1'b0;
        jdo = '0;
        take_action_ocimem_a = 1'b0; take_no_action_ocimem_a = 1'b0; take_action_ocimem_b = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_state", {MonDReg, MonAReg, monitor_ready, monitor_error, mem_address,
                              mem_read, mem_write, mem_writedata}, 96'h0);
        reset_n = 1'b1;

        // reset while a write is stalled
        hold_wait = 1'b1;
        strobe(1'b0, 1'b0, 1'b1, mk_write(32'hDEADBEEF));
        check("rst_wr_req", {mem_write, mem_writedata}, {1'b1, 32'hDEADBEEF});
        @(negedge clk);
        check("rst_wr_stall", mem_write, 1'b1);
        reset_n = 1'b0;
        @(negedge clk);
        check("rst_mid_write", {MonDReg, MonAReg, monitor_ready, monitor_error, mem_address,
                                mem_read, mem_write, mem_writedata}, 96'h0);
        reset_n = 1'b1;
        hold_wait = 1'b0;

        // address load with read, 2 wait states, data one cycle after accept
        cfg_stall = 2; cfg_lat = 1;
        model_load(8'h3C, 1'b1, 1'b0);
        strobe(1'b1, 1'b0, 1'b0, mk_load(8'h3C, 1'b1, 1'b0));
        check("ld_rd_addr", {mem_read, mem_address}, {1'b1, 8'h3C});
        wait_done(nreq);
        check("ld_rd_cycles", nreq, 3);
        check("ld_rd_result", {MonDReg, MonAReg, monitor_ready}, {32'hCAFEF00D, 8'h3C, 1'b1});

        // burst writes wrapping past 8'hFF
        cfg_stall = 0; cfg_lat = -1;
        model_load(8'hFF, 1'b0, 1'b0);
        strobe(1'b1, 1'b0, 1'b0, mk_load(8'hFF, 1'b0, 1'b0));
        check("ld_only", {MonAReg, monitor_ready, mem_read}, {8'hFF, 1'b1, 1'b0});
        model_write(32'h12345678);
        strobe(1'b0, 1'b0, 1'b1, mk_write(32'h12345678));
        wait_done(nreq);
        model_write(32'h9ABCDEF0);
        strobe(1'b0, 1'b0, 1'b1, mk_write(32'h9ABCDEF0));
        wait_done(nreq);
        check("wrap_addr", MonAReg, 8'h01);

        // increment-and-read
        cfg_stall = -1;
        model_load(8'h10, 1'b0, 1'b0);
        strobe(1'b1, 1'b0, 1'b0, mk_load(8'h10, 1'b0, 1'b0));
        model_inc();
        strobe(1'b0, 1'b1, 1'b0, rnd_jdo());
        check("inc_rd_addr", {mem_read, mem_address}, {1'b1, 8'h11});
        wait_done(nreq);
        check("inc_rd_areg", MonAReg, 8'h11);

        // timeout on a permanently stalled read
        hold_wait = 1'b1;
        ref_addr = 8'h55; ref_err = 1'b1; ref_ready = 1'b1;
        push_done();
        strobe(1'b1, 1'b0, 1'b0, mk_load(8'h55, 1'b1, 1'b0));
        wait_done(nreq);
        check("tmo_cycles", nreq, TMO);
        check("tmo_flags", {monitor_error, monitor_ready, mem_read}, {1'b1, 1'b1, 1'b0});
        hold_wait = 1'b0;
        model_load(8'h20, 1'b0, 1'b1);
        strobe(1'b1, 1'b0, 1'b0, mk_load(8'h20, 1'b0, 1'b1));
        check("err_clear", {monitor_error, MonAReg}, {1'b0, 8'h20});

        // write strobe while a read sits in RD_WAIT
        cfg_stall = 0; cfg_lat = 3;
        ref_err = 1'b1;
        model_load(8'h40, 1'b1, 1'b0);
        strobe(1'b1, 1'b0, 1'b0, mk_load(8'h40, 1'b1, 1'b0));
        strobe(1'b0, 1'b0, 1'b1, mk_write(32'h0BADF00D));
        wait_done(nreq);
        check("collide", {monitor_error, MonAReg, MonDReg}, {1'b1, 8'h40, ref_mem[8'h40]});

        // a and b together: only the write runs, error stays set
        cfg_stall = -1; cfg_lat = -1;
        j = mk_write($urandom());
        j[35] = 1'b1; j[34] = 1'b1;
        model_write(j[34:3]);
        strobe(1'b1, 1'b0, 1'b1, j);
        wait_done(nreq);
        check("a_plus_b", {monitor_error, MonAReg}, {1'b1, 8'h41});

        // random command mix
        for (int k = 0; k < 60; k++) begin
            a = 8'($urandom());
            clr = 1'($urandom());
            case ($urandom_range(0, 3))
                0: begin
                    model_load(a, 1'b1, clr);
                    strobe(1'b1, 1'b0, 1'b0, mk_load(a, 1'b1, clr));
                    wait_done(nreq);
                end
                1: begin
                    model_load(a, 1'b0, clr);
                    strobe(1'b1, 1'b0, 1'b0, mk_load(a, 1'b0, clr));
                    check("rnd_ld_only", {MonAReg, monitor_error, monitor_ready}, {ref_addr, ref_err, 1'b1});
                end
                2: begin
                    model_inc();
                    strobe(1'b0, 1'b1, 1'b0, rnd_jdo());
                    wait_done(nreq);
                end
                default: begin
                    j = mk_write($urandom());
                    model_write(j[34:3]);
                    strobe(1'b0, 1'b0, 1'b1, j);
                    wait_done(nreq);
                end
            endcase
        end

        // read back a few written words to confirm memory contents
        for (int k = 0; k < 4; k++) begin
            rd = 1'b1;
            a = 8'h3F + 8'(k);
            model_load(a, rd, 1'b0);
            strobe(1'b1, 1'b0, 1'b0, mk_load(a, rd, 1'b0));
            wait_done(nreq);
        end

        repeat (5) @(negedge clk);
        check("bus_q_drained", bus_q.size(), 0);
        check("done_q_drained", done_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/nios2_ocimem_monitor_port.md
Name: nios2_ocimem_monitor_port

Overview:
- Sysclk-domain consumer of the JTAG debug module's decoded strobes (`jdo`, `take_action_ocimem_a/b`, `take_no_action_ocimem_a`).
- Turns host debug commands into single-word reads and writes on an Avalon-style master to the OCI debug memory or monitor.
- Returns read data and completion status (`MonDReg`, `monitor_ready`, `monitor_error`) to the debug module for shift-out.
- Sits between the debug module's sysclk stage and the debug RAM/monitor slave.

Parameters:
- ADDR_W, 8, word-address width of the memory side; legal range 1..24.
- TIMEOUT_CYCLES, 256, maximum cycles for one transfer before abort; legal range 2..65535.

Ports:
- clk  in  1  system clock
- reset_n  in  1  reset
- jdo  in  38  command payload from debug module
- take_action_ocimem_a  in  1  address-load command strobe (1 cycle)
- take_no_action_ocimem_a  in  1  increment-and-read command strobe (1 cycle)
- take_action_ocimem_b  in  1  write-data command strobe (1 cycle)
- MonDReg  out  32  last read data
- MonAReg  out  ADDR_W  current word address
- monitor_ready  out  1  last command complete
- monitor_error  out  1  sticky error flag
- mem_address  out  ADDR_W  master address
- mem_read  out  1  read request
- mem_write  out  1  write request
- mem_writedata  out  32  write data
- mem_waitrequest  in  1  slave stall
- mem_readdata  in  32  read data
- mem_readdatavalid  in  1  read data valid

Behaviour:
- Interface: one clock, `clk`; reset `reset_n` is synchronous and active-low. On the reset edge all outputs go to 0 and the FSM goes to IDLE, including mid-transfer; `mem_read`/`mem_write` deassert after that edge.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ.
- Command strobes are decoded only in IDLE. Priority when several strobes are high together: b > a > no_action_a.
- Strobe in a non-IDLE state: dropped, `monitor_error` <= 1, transfer in progress unaffected.
- take_action_ocimem_a:
  - `MonAReg` <= `jdo[ADDR_W+1:2]`.
  - If `jdo[35]`=1, `monitor_error` <= 0.
  - If `jdo[34]`=1: `monitor_ready` <= 0, go to RD_REQ at the new address.
  - Otherwise `monitor_ready` <= 1, stay in IDLE.
- take_no_action_ocimem_a: `MonAReg` <= `MonAReg`+1 (wraps modulo 2^ADDR_W); `monitor_ready` <= 0; go to RD_REQ at the incremented address.
- take_action_ocimem_b: `mem_writedata` <= `jdo[34:3]`; `monitor_ready` <= 0; go to WR_REQ at the current `MonAReg`.
- `mem_address` always equals `MonAReg`.
- RD_REQ:
  - `mem_read`=1, held until a cycle with `mem_waitrequest`=0.
  - On that cycle: go to RD_WAIT.
  - If `mem_readdatavalid` is also 1 on that same cycle: capture `mem_readdata`, complete immediately.
- RD_WAIT: on `mem_readdatavalid`=1, `MonDReg` <= `mem_readdata`, `monitor_ready` <= 1, go to IDLE. `MonAReg` is not changed by a read.
- WR_REQ:
  - `mem_write`=1, held until a cycle with `mem_waitrequest`=0.
  - On that cycle: `MonAReg` <= `MonAReg`+1 (wraps), `monitor_ready` <= 1, go to IDLE.
- Command-to-request latency: `mem_read`/`mem_write` asserts on the cycle after the strobe.
- Timeout:
  - A 16-bit counter clears on leaving IDLE and increments every non-IDLE cycle.
  - If the transfer has not completed when the counter reaches TIMEOUT_CYCLES-1: deassert requests next cycle, go to IDLE, `monitor_error` <= 1, `monitor_ready` <= 1.
  - `MonDReg` and `MonAReg` are unchanged on timeout.
- `mem_readdatavalid` arriving in IDLE or WR_REQ (e.g. late data after a timeout) is ignored.
- `monitor_error` is sticky; it is cleared only by reset or by an ocimem_a command with `jdo[35]`=1.

Test Plan:
- Reset mid-write: assert `reset_n`=0 during WR_REQ with `mem_waitrequest`=1 -> next cycle `mem_write`=0, all outputs 0, FSM in IDLE; a subsequent read behaves normally.
- Address load with read: ocimem_a with `jdo[9:2]`=8'h3C, `jdo[34]`=1; slave waits 2 cycles then returns 32'hCAFEF00D with `mem_readdatavalid` 1 cycle later -> `mem_read` high for 3 cycles at address 8'h3C, `MonDReg`=32'hCAFEF00D, `monitor_ready`=1, `MonAReg`=8'h3C.
- Burst writes with wrap: `MonAReg`=8'hFF, ocimem_b with `jdo[34:3]`=32'h12345678, then ocimem_b with 32'h9ABCDEF0, zero waitrequest -> writes land at addresses 8'hFF then 8'h00, final `MonAReg`=8'h01.
- Increment-read: from `MonAReg`=8'h10, take_no_action_ocimem_a -> read issued at 8'h11, `MonAReg`=8'h11 after completion.
- Timeout, TIMEOUT_CYCLES=8: `mem_waitrequest` held high on a read -> `mem_read` drops after 8 cycles, `monitor_error`=1, `monitor_ready`=1, `MonDReg` unchanged. Then ocimem_a with `jdo[35]`=1 -> `monitor_error`=0.
- Collision: ocimem_b strobe while in RD_WAIT -> no write issued, `monitor_error`=1, the read still completes with correct data. Simultaneous a+b strobes in IDLE -> only the write executes.
